// File: rtl/ofifo_deskew.sv
// Output deskew bank: one FIFO per MAC-array column absorbs the diagonal
// arrival skew, and a single read pops one aligned row from all columns.
module ofifo_deskew #(
  parameter int col   = 8,
  parameter int bw    = 16,
  parameter int depth = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [col-1:0]      wr,
  input  logic [bw*col-1:0]   in,
  input  logic                rd,
  output logic [bw*col-1:0]   out,
  output logic                o_out_valid,
  output logic                o_valid,
  output logic                o_full,
  output logic                o_ready,
  output logic                o_overflow
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = AW + 1;

  logic [bw-1:0]       mem_q [col][depth];
  logic [CW-1:0]       wptr_q [col];
  logic [CW-1:0]       wptr_d [col];
  logic [CW-1:0]       rptr_q [col];
  logic [CW-1:0]       rptr_d [col];
  logic [CW-1:0]       cnt_q  [col];
  logic [CW-1:0]       cnt_d  [col];
  logic [bw*col-1:0]   out_q;
  logic [bw*col-1:0]   out_d;
  logic                out_valid_q;
  logic                out_valid_d;
  logic                overflow_q;
  logic                overflow_d;
  logic [col-1:0]      empty;
  logic [col-1:0]      full;
  logic [col-1:0]      wr_acc;
  logic                rd_acc;

  always_comb begin
    for (int i = 0; i < col; i++) begin
      empty[i] = (cnt_q[i] == '0);
      full[i]  = (cnt_q[i] == CW'(depth));
    end
  end

  // Handshake: wr[i] is accepted when column i is not full (judged on the
  // pre-edge count); rd is accepted only when o_valid, and the popped row
  // appears on out with o_out_valid one edge later.
  assign wr_acc  = wr & ~full;
  assign o_valid = &(~empty);
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign rd_acc  = rd & o_valid;

  always_comb begin
    out_d       = out_q;
    out_valid_d = rd_acc;
    overflow_d  = overflow_q | (|(wr & full));
    for (int i = 0; i < col; i++) begin
      wptr_d[i] = wptr_q[i] + {{AW{1'b0}}, wr_acc[i]};
      rptr_d[i] = rptr_q[i] + {{AW{1'b0}}, rd_acc};
      cnt_d[i]  = cnt_q[i] + {{AW{1'b0}}, wr_acc[i]} - {{AW{1'b0}}, rd_acc};
      if (rd_acc) begin
        out_d[i*bw +: bw] = mem_q[i][rptr_q[i][AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < col; i++) begin
        if (wr_acc[i]) begin
          mem_q[i][wptr_q[i][AW-1:0]] <= in[i*bw +: bw];
        end
      end
    end
  end

  assign out         = out_q;
  assign o_out_valid = out_valid_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_ofifo_deskew.sv
// Bench for ofifo_deskew: scenario tasks drive rows, a queue of expected
// rows is filled on write and consumed whenever the DUT presents a row.
module tb_ofifo_deskew;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int W   = COL * BW;

  logic             clk;
  logic             reset;
  logic [COL-1:0]   wr;
  logic [W-1:0]     in_bus;
  logic             rd;
  logic [W-1:0]     out;
  logic             o_out_valid;
  logic             o_valid;
  logic             o_full;
  logic             o_ready;
  logic             o_overflow;

  logic [W-1:0]     exp_q[$];
  int               n_checks;
  int               n_fail;

  ofifo_deskew #(.col(COL), .bw(BW), .depth(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .in         (in_bus),
    .rd         (rd),
    .out        (out),
    .o_out_valid(o_out_valid),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = '0; rd = 1'b0; in_bus = '0;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Pops one row with rd while optionally driving a concurrent write.
  task automatic read_row(input string name, input logic [COL-1:0] wr_v,
                          input logic [W-1:0] in_v);
    logic [W-1:0] exp;
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_valid_before_rd: got %b want 1", name, o_valid);
    end
    rd = 1'b1; wr = wr_v; in_bus = in_v;
    tick();
    rd = 1'b0; wr = '0;
    n_checks++;
    if (o_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_out_valid: got %b want 1", name, o_out_valid);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s_scoreboard: got row %h want none queued", name, out);
    end else begin
      exp = exp_q.pop_front();
      if (out !== exp) begin
        n_fail++; $display("FAIL %s_row: got %h want %h", name, out, exp);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 6;
    if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", o_out_valid); end
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", o_full); end
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
  endtask

  task automatic test_skewed_fill();
    logic [W-1:0] row;
    do_reset();
    row = '0;
    for (int c = 0; c < COL; c++) begin
      n_checks++;
      if (o_valid !== 1'b0) begin
        n_fail++; $display("FAIL skew_valid_early_c%0d: got %b want 0", c, o_valid);
      end
      wr = '0; wr[c] = 1'b1;
      in_bus = '0; in_bus[c*BW +: BW] = 16'h0100 + 16'(c);
      row[c*BW +: BW] = 16'h0100 + 16'(c);
      tick();
    end
    wr = '0;
    exp_q.push_back(row);
    read_row("skew", '0, '0);
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL skew_valid_after: got %b want 0", o_valid); end
    tick();
    n_checks++;
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL skew_pulse_len: got %b want 0", o_out_valid); end
  endtask

  task automatic test_full_overflow();
    logic [W-1:0] row;
    logic [W-1:0] dead;
    do_reset();
    dead = {COL{16'hDEAD}};
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < COL; c++) row[c*BW +: BW] = 16'h1000 + 16'(r*16 + c);
      wr = '1; in_bus = row;
      exp_q.push_back(row);
      tick();
    end
    wr = '0;
    n_checks += 3;
    if (o_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", o_full); end
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", o_ready); end
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf_early: got %b want 0", o_overflow); end
    wr = '1; in_bus = dead;
    tick();
    wr = '0;
    n_checks++;
    if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
    // A write to a full column in the same cycle as a pop is still dropped.
    read_row("full_r0", '1, dead);
    n_checks += 2;
    if (o_full !== 1'b0) begin n_fail++; $display("FAIL full_drop_after_rd: got %b want 0", o_full); end
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_rd: got %b want 1", o_ready); end
    for (int r = 1; r < 8; r++) read_row($sformatf("full_r%0d", r), '0, '0);
    n_checks += 2;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained_valid: got %b want 0", o_valid); end
    if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
  endtask

  task automatic test_empty_read();
    logic [W-1:0] row;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      rd = 1'b1;
      tick();
      n_checks += 3;
      if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_out_valid_%0d: got %b want 0", k, o_out_valid); end
      if (out !== '0) begin n_fail++; $display("FAIL empty_out_%0d: got %h want 0", k, out); end
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid_%0d: got %b want 0", k, o_valid); end
    end
    rd = 1'b0;
    // Pointers must not have moved: a single row reads back intact.
    for (int c = 0; c < COL; c++) row[c*BW +: BW] = 16'($urandom_range(0, 16'hFFFF));
    wr = '1; in_bus = row; exp_q.push_back(row);
    tick();
    wr = '0;
    read_row("empty_follow", '0, '0);
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL empty_follow_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_partial_row();
    logic [W-1:0] row;
    do_reset();
    for (int c = 0; c < COL; c++) row[c*BW +: BW] = 16'h2200 + 16'(c);
    wr = 8'h7F; in_bus = row;
    tick();
    wr = '0; rd = 1'b1;
    tick();
    rd = 1'b0;
    n_checks += 3;
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_out_valid: got %b want 0", o_out_valid); end
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL partial_valid: got %b want 0", o_valid); end
    if (out !== '0) begin n_fail++; $display("FAIL partial_out: got %h want 0", out); end
    wr = 8'h80; in_bus = row;
    exp_q.push_back(row);
    tick();
    wr = '0;
    read_row("partial", '0, '0);
  endtask

  task automatic test_wrap();
    int got;
    int t;
    logic [W-1:0] row;
    logic [W-1:0] exp;
    do_reset();
    got = 0;
    t = 0;
    // Column c writes row r at cycle 2r+c: skewed, and wraps depth twice.
    while (got < 20 && t < 300) begin
      wr = '0; in_bus = '0;
      for (int c = 0; c < COL; c++) begin
        if (t >= c && ((t - c) % 2 == 0) && ((t - c) / 2 < 20)) begin
          wr[c] = 1'b1;
          in_bus[c*BW +: BW] = 16'(((t - c) / 2) * 16 + c);
        end
      end
      if (wr[COL-1]) begin
        for (int c = 0; c < COL; c++) row[c*BW +: BW] = 16'(((t - COL + 1) / 2) * 16 + c);
        exp_q.push_back(row);
      end
      rd = o_valid;
      tick();
      if (o_out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL wrap_scoreboard_%0d: got row %h want none queued", got, out);
        end else begin
          exp = exp_q.pop_front();
          if (out !== exp) begin n_fail++; $display("FAIL wrap_row_%0d: got %h want %h", got, out, exp); end
        end
        got++;
      end
      t++;
    end
    wr = '0; rd = 1'b0;
    n_checks += 3;
    if (got != 20) begin n_fail++; $display("FAIL wrap_count: got %0d want 20", got); end
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_overflow: got %b want 0", o_overflow); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] row;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < COL; c++) row[c*BW +: BW] = 16'h3000 + 16'(r*16 + c);
      wr = '1; in_bus = row; exp_q.push_back(row);
      tick();
    end
    wr = '0;
    read_row("mid_pre", '0, '0);
    reset = 1'b1; rd = 1'b1; wr = '1; in_bus = {COL{16'hBEEF}};
    tick();
    reset = 1'b0; rd = 1'b0; wr = '0;
    exp_q.delete();
    n_checks += 6;
    if (out !== '0) begin n_fail++; $display("FAIL mid_out: got %h want 0", out); end
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", o_out_valid); end
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", o_valid); end
    if (o_full !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b want 0", o_full); end
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", o_ready); end
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b want 0", o_overflow); end
    for (int c = 0; c < COL; c++) row[c*BW +: BW] = 16'h4400 + 16'(c);
    wr = '1; in_bus = row; exp_q.push_back(row);
    tick();
    wr = '0;
    read_row("mid_post", '0, '0);
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid: got %b want 0", o_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; wr = '0; rd = 1'b0; in_bus = '0;
    repeat (2) tick();
    test_reset();
    test_skewed_fill();
    test_full_overflow();
    test_empty_read();
    test_partial_row();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
